// File: rtl/pri_decoder_pipe_if.sv
// Handshake bundle for the priority-decoder receive link: code-word input side
// and decoded one-hot output side, each with its own valid/ready pair.
interface pri_decoder_pipe_if #(
  parameter int N_SEL = 2,
  parameter int OUT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic             in_v;
  logic [N_SEL-1:0] in_y;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_onehot;
  logic             out_none;

  // Master is the environment: it sources code words and sinks decoded words.
  modport master (
    output in_valid,
    output in_v,
    output in_y,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_onehot,
    input  out_none
  );

  modport slave (
    input  in_valid,
    input  in_v,
    input  in_y,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_onehot,
    output out_none
  );
endinterface

// File: rtl/pri_decoder_pipe.sv
// Decodes {v, y} priority-encoder words into a one-hot vector through a 2-entry
// skid buffer with registered in_ready, plus saturating per-line hit counters.
module pri_decoder_pipe #(
  parameter int N_SEL = 2,
  parameter int OUT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  pri_decoder_pipe_if.slave bus,
  input  logic [N_SEL-1:0] cnt_sel,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_q
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [OUT_W:0]   head_q, head_d;
  logic [OUT_W:0]   tail_q, tail_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] hits_q [OUT_W];
  logic [CNT_W-1:0] hits_d [OUT_W];

  logic             push;
  logic             pop;
  logic [OUT_W-1:0] dec_onehot;
  logic [OUT_W:0]   dec_entry;

  assign push = bus.in_valid & in_ready_q;
  assign pop  = (state_q != S_EMPTY) & bus.out_ready;

  // Entry layout is {none, onehot}; decoding happens once, at push time.
  assign dec_onehot = bus.in_v ? (OUT_W'(1) << bus.in_y) : '0;
  assign dec_entry  = {~bus.in_v, dec_onehot};

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      S_EMPTY: begin
        if (push) begin
          head_d  = dec_entry;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (push && pop) begin
          head_d = dec_entry;
        end else if (push) begin
          tail_d  = dec_entry;
          state_d = S_TWO;
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = S_ONE;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
    // Registered ready tracks the occupancy we are about to enter.
    in_ready_d = (state_d != S_TWO);
  end

  always_comb begin
    for (int i = 0; i < OUT_W; i++) begin
      hits_d[i] = hits_q[i];
      if (cnt_clr) begin
        hits_d[i] = '0;
      end else if (pop && !head_q[OUT_W] && head_q[i] && (hits_q[i] != CNT_MAX)) begin
        hits_d[i] = hits_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b1;
      hits_q     <= '{default: '0};
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
      hits_q     <= hits_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = (state_q != S_EMPTY);
  assign bus.out_onehot = head_q[OUT_W-1:0];
  assign bus.out_none   = head_q[OUT_W];
  assign cnt_q          = hits_q[cnt_sel];

endmodule

// File: tb/tb_pri_decoder_pipe.sv
// Directed, self-checking bench for pri_decoder_pipe: reset, decode, back-pressure,
// streaming with counter saturation/clear, and reset while words are buffered.
module tb_pri_decoder_pipe;
  logic       clk;
  logic       rst_n;
  logic [1:0] cnt_sel;
  logic       cnt_clr;
  logic [7:0] cnt_q;

  int n_cmp;
  int n_err;

  pri_decoder_pipe_if #(.N_SEL(2), .OUT_W(4)) bus ();

  pri_decoder_pipe #(.N_SEL(2), .OUT_W(4), .CNT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .cnt_sel (cnt_sel),
    .cnt_clr (cnt_clr),
    .cnt_q   (cnt_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_v     = 1'b1;
    bus.in_y     = 2'd0;
    bus.out_ready = 1'b0;
    cnt_clr      = 1'b0;
    cnt_sel      = 2'd0;
    tick();
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    for (int s = 0; s < 4; s++) begin
      cnt_sel = 2'(s);
      #1;
      n_cmp++;
      if (cnt_q !== 8'd0) begin
        n_err++;
        $display("[TB] FAIL reset_cnt_q[%0d]: got %0d expected 0", s, cnt_q);
      end
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_no_push: got out_valid %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_decode_hit();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_v      = 1'b1;
    bus.in_y      = 2'b10;
    tick();
    bus.in_valid = 1'b0;
    n_cmp++;
    if ({bus.out_valid, bus.out_onehot, bus.out_none} !== {1'b1, 4'b0100, 1'b0}) begin
      n_err++;
      $display("[TB] FAIL decode_y2: got v=%b oh=%b none=%b expected v=1 oh=0100 none=0",
               bus.out_valid, bus.out_onehot, bus.out_none);
    end
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL decode_y2_popped: got out_valid %b expected 0", bus.out_valid);
    end
    cnt_sel = 2'd2;
    #1;
    n_cmp++;
    if (cnt_q !== 8'd1) begin
      n_err++;
      $display("[TB] FAIL cnt_line2: got %0d expected 1", cnt_q);
    end
  endtask

  task automatic test_decode_none();
    logic [7:0] exp_cnt [4];
    exp_cnt = '{8'd0, 8'd0, 8'd1, 8'd0};
    bus.in_valid = 1'b1;
    bus.in_v     = 1'b0;
    bus.in_y     = 2'b11;
    tick();
    bus.in_valid = 1'b0;
    n_cmp++;
    if ({bus.out_valid, bus.out_onehot, bus.out_none} !== {1'b1, 4'b0000, 1'b1}) begin
      n_err++;
      $display("[TB] FAIL decode_none: got v=%b oh=%b none=%b expected v=1 oh=0000 none=1",
               bus.out_valid, bus.out_onehot, bus.out_none);
    end
    tick();
    for (int s = 0; s < 4; s++) begin
      cnt_sel = 2'(s);
      #1;
      n_cmp++;
      if (cnt_q !== exp_cnt[s]) begin
        n_err++;
        $display("[TB] FAIL none_cnt[%0d]: got %0d expected %0d", s, cnt_q, exp_cnt[s]);
      end
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_v      = 1'b1;
    bus.in_y      = 2'd0;
    tick();
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL bp_ready_after_1: got %b expected 1", bus.in_ready);
    end
    bus.in_y = 2'd1;
    tick();
    n_cmp++;
    if ({bus.in_ready, bus.out_valid, bus.out_onehot} !== {1'b0, 1'b1, 4'b0001}) begin
      n_err++;
      $display("[TB] FAIL bp_full: got rdy=%b v=%b oh=%b expected rdy=0 v=1 oh=0001",
               bus.in_ready, bus.out_valid, bus.out_onehot);
    end
    bus.in_y = 2'd2;
    tick();
    n_cmp++;
    if ({bus.in_ready, bus.out_onehot} !== {1'b0, 4'b0001}) begin
      n_err++;
      $display("[TB] FAIL bp_hold: got rdy=%b oh=%b expected rdy=0 oh=0001",
               bus.in_ready, bus.out_onehot);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    n_cmp++;
    if ({bus.in_ready, bus.out_valid, bus.out_onehot} !== {1'b1, 1'b1, 4'b0010}) begin
      n_err++;
      $display("[TB] FAIL bp_second: got rdy=%b v=%b oh=%b expected rdy=1 v=1 oh=0010",
               bus.in_ready, bus.out_valid, bus.out_onehot);
    end
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL bp_refused_word: got out_valid %b oh=%b expected 0",
               bus.out_valid, bus.out_onehot);
    end
    cnt_sel = 2'd0;
    #1;
    n_cmp++;
    if (cnt_q !== 8'd1) begin
      n_err++;
      $display("[TB] FAIL bp_cnt_line0: got %0d expected 1", cnt_q);
    end
    cnt_sel = 2'd1;
    #1;
    n_cmp++;
    if (cnt_q !== 8'd1) begin
      n_err++;
      $display("[TB] FAIL bp_cnt_line1: got %0d expected 1", cnt_q);
    end
  endtask

  task automatic test_back_to_back();
    int gaps;
    gaps = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_v      = 1'b1;
    bus.in_y      = 2'b11;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (!(bus.out_valid && bus.in_ready && bus.out_onehot == 4'b1000)) gaps++;
    end
    bus.in_valid = 1'b0;
    n_cmp++;
    if (gaps !== 0) begin
      n_err++;
      $display("[TB] FAIL stream_gaps: got %0d stalled cycles expected 0", gaps);
    end
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL stream_drain: got out_valid %b expected 0", bus.out_valid);
    end
    cnt_sel = 2'd3;
    #1;
    n_cmp++;
    if (cnt_q !== 8'd255) begin
      n_err++;
      $display("[TB] FAIL cnt_saturate: got %0d expected 255", cnt_q);
    end
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    #1;
    n_cmp++;
    if (cnt_q !== 8'd0) begin
      n_err++;
      $display("[TB] FAIL cnt_clear_vs_pop: got %0d expected 0", cnt_q);
    end
    cnt_sel = 2'd0;
    #1;
    n_cmp++;
    if (cnt_q !== 8'd0) begin
      n_err++;
      $display("[TB] FAIL cnt_clear_line0: got %0d expected 0", cnt_q);
    end
  endtask

  task automatic test_reset_midflight();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_v      = 1'b1;
    bus.in_y      = 2'd0;
    tick();
    bus.in_y = 2'd2;
    tick();
    bus.in_valid = 1'b0;
    n_cmp++;
    if ({bus.out_valid, bus.in_ready} !== 2'b10) begin
      n_err++;
      $display("[TB] FAIL mid_full: got v=%b rdy=%b expected v=1 rdy=0",
               bus.out_valid, bus.in_ready);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_err++;
      $display("[TB] FAIL mid_async_reset: got v=%b rdy=%b expected v=0 rdy=1",
               bus.out_valid, bus.in_ready);
    end
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_y      = 2'b01;
    tick();
    bus.in_valid = 1'b0;
    n_cmp++;
    if ({bus.out_valid, bus.out_onehot, bus.out_none} !== {1'b1, 4'b0010, 1'b0}) begin
      n_err++;
      $display("[TB] FAIL mid_first_push: got v=%b oh=%b none=%b expected v=1 oh=0010 none=0",
               bus.out_valid, bus.out_onehot, bus.out_none);
    end
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL mid_no_stale: got out_valid %b oh=%b expected 0",
               bus.out_valid, bus.out_onehot);
    end
    cnt_sel = 2'd1;
    #1;
    n_cmp++;
    if (cnt_q !== 8'd1) begin
      n_err++;
      $display("[TB] FAIL mid_cnt_line1: got %0d expected 1", cnt_q);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_decode_hit();
    test_decode_none();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
